// File: rtl/synth_pkg.sv
// Shared voice state and waveform encodings plus the phase-to-waveform shaper.
// Combinational helpers only: no latency, no flow control.
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    RELEASE = 2'd2
  } voice_state_t;

  typedef enum logic [1:0] {
    SQUARE = 2'd0,
    SAW    = 2'd1,
    TRI    = 2'd2,
    SILENT = 2'd3
  } wave_t;

  // Shaper works at a fixed width; callers zero-extend their slices in and keep the low SAMPLE_W bits.
  localparam int WAVE_MAX_W = 32;

  function automatic logic [WAVE_MAX_W-1:0] shape_wave(
    input wave_t                 sel,
    input logic                  msb,
    input logic [WAVE_MAX_W-1:0] saw_v,
    input logic [WAVE_MAX_W-1:0] tri_v
  );
    logic [WAVE_MAX_W-1:0] w;
    case (sel)
      SQUARE:  w = msb ? '1 : '0;
      SAW:     w = saw_v;
      TRI:     w = msb ? ~tri_v : tri_v;
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/synth_voice.sv
// One voice: state, phase accumulator, release amplitude, waveshaping and amplitude scaling.
// Control inputs take effect at the next edge; voice_out is combinational from registered state.
module synth_voice
  import synth_pkg::*;
#(
  parameter int PHASE_W  = 16,
  parameter int SAMPLE_W = 8,
  parameter int AMP_W    = 4,
  parameter int KEY_W    = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                en,
  input  logic                load,
  input  logic                retrig,
  input  logic                rel,
  input  logic                decay_tick,
  input  logic [KEY_W-1:0]    key_code,
  input  logic [PHASE_W-1:0]  key_step,
  input  wave_t               wave_sel,
  output voice_state_t        state,
  output logic [KEY_W-1:0]    code,
  output logic [SAMPLE_W-1:0] voice_out
);

  localparam logic [AMP_W-1:0] AMP_MAX = {AMP_W{1'b1}};

  logic [PHASE_W-1:0]        step;
  logic [PHASE_W-1:0]        phase;
  logic [AMP_W-1:0]          amp;
  logic [WAVE_MAX_W-1:0]     saw_ext;
  logic [WAVE_MAX_W-1:0]     tri_ext;
  logic [WAVE_MAX_W-1:0]     wave_full;
  logic [SAMPLE_W-1:0]       wave;
  logic [SAMPLE_W+AMP_W-1:0] scaled;
  logic                      unused_wave;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      code  <= '0;
      step  <= '0;
      phase <= '0;
      amp   <= '0;
    end else if (load) begin
      state <= HELD;
      code  <= key_code;
      step  <= key_step;
      phase <= '0;
      amp   <= AMP_MAX;
    end else begin
      if (en && state != IDLE) phase <= phase + step;
      // Retrigger outranks a decay tick landing on the same edge.
      if (retrig) begin
        state <= HELD;
        amp   <= AMP_MAX;
        step  <= key_step;
      end else if (rel) begin
        state <= RELEASE;
      end else if (decay_tick && state == RELEASE) begin
        amp <= (amp == '0) ? '0 : amp - AMP_W'(1);
        if (amp <= AMP_W'(1)) state <= IDLE;
      end
    end
  end

  always_comb begin
    saw_ext = '0;
    tri_ext = '0;
    saw_ext[SAMPLE_W-1:0] = phase[PHASE_W-1 -: SAMPLE_W];
    tri_ext[SAMPLE_W-1:0] = phase[PHASE_W-2 -: SAMPLE_W];
  end

  assign wave_full   = shape_wave(wave_sel, phase[PHASE_W-1], saw_ext, tri_ext);
  assign wave        = wave_full[SAMPLE_W-1:0];
  assign unused_wave = ^wave_full[WAVE_MAX_W-1:SAMPLE_W];

  assign scaled    = {{AMP_W{1'b0}}, wave} * {{SAMPLE_W{1'b0}}, amp};
  assign voice_out = (state == IDLE) ? '0 : scaled[SAMPLE_W+AMP_W-1:AMP_W];

endmodule

// File: rtl/poly_voice_engine.sv
// Polyphonic voice allocator and mixer: key events land one cycle after the strobe, samples on each sample tick.
// No backpressure: presses with no free voice are dropped and flagged on key_drop_o.
module poly_voice_engine
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 16,
  parameter int SAMPLE_W   = 8,
  parameter int AMP_W      = 4,
  parameter int KEY_W      = 4,
  parameter int SAMPLE_DIV = 256,
  parameter int DECAY_DIV  = 4096
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  en,
  input  logic                  key_valid,
  input  logic                  key_on,
  input  logic [KEY_W-1:0]      key_code,
  input  logic [PHASE_W-1:0]    key_step,
  input  logic [1:0]            wave_sel,
  output logic [SAMPLE_W-1:0]   sample_o,
  output logic                  sample_valid,
  output logic [NUM_VOICES-1:0] voice_busy_o,
  output logic                  key_drop_o
);

  localparam int LOG_NV = $clog2(NUM_VOICES);
  localparam int SUM_W  = SAMPLE_W + LOG_NV;
  localparam int SCNT_W = $clog2(SAMPLE_DIV);
  localparam int DCNT_W = $clog2(DECAY_DIV);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SAMPLE_DIV - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECAY_DIV - 1);

  voice_state_t        v_state [NUM_VOICES];
  logic [KEY_W-1:0]    v_code  [NUM_VOICES];
  logic [SAMPLE_W-1:0] v_out   [NUM_VOICES];

  logic [NUM_VOICES-1:0] idle_vec, hit_busy, hit_held;
  logic [NUM_VOICES-1:0] load_vec, retrig_vec, rel_vec;
  logic                  drop_evt;
  logic [SCNT_W-1:0]     scnt;
  logic [DCNT_W-1:0]     dcnt;
  logic                  sample_tick, decay_tick;
  logic [SUM_W-1:0]      mix_sum;
  logic [SAMPLE_W-1:0]   mix_sample;

  function automatic logic [NUM_VOICES-1:0] lowest_set(input logic [NUM_VOICES-1:0] v);
    return v & (~v + NUM_VOICES'(1));
  endfunction

  assign sample_tick = en && (scnt == SCNT_LAST);
  assign decay_tick  = en && (dcnt == DCNT_LAST);

  // Allocation sees only registered voice state, so a voice hitting amp 0 this edge is still busy.
  always_comb begin
    idle_vec   = '0;
    hit_busy   = '0;
    hit_held   = '0;
    load_vec   = '0;
    retrig_vec = '0;
    rel_vec    = '0;
    drop_evt   = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      idle_vec[i] = (v_state[i] == IDLE);
      hit_busy[i] = (v_state[i] != IDLE) && (v_code[i] == key_code);
      hit_held[i] = (v_state[i] == HELD) && (v_code[i] == key_code);
    end
    if (key_valid && key_on) begin
      if (|hit_busy)      retrig_vec = lowest_set(hit_busy);
      else if (|idle_vec) load_vec   = lowest_set(idle_vec);
      else                drop_evt   = 1'b1;
    end else if (key_valid) begin
      rel_vec = lowest_set(hit_held);
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    synth_voice #(
      .PHASE_W  (PHASE_W),
      .SAMPLE_W (SAMPLE_W),
      .AMP_W    (AMP_W),
      .KEY_W    (KEY_W)
    ) u_voice (
      .clk        (clk),
      .n_rst      (n_rst),
      .en         (en),
      .load       (load_vec[i]),
      .retrig     (retrig_vec[i]),
      .rel        (rel_vec[i]),
      .decay_tick (decay_tick),
      .key_code   (key_code),
      .key_step   (key_step),
      .wave_sel   (wave_t'(wave_sel)),
      .state      (v_state[i]),
      .code       (v_code[i]),
      .voice_out  (v_out[i])
    );
    assign voice_busy_o[i] = (v_state[i] != IDLE);
  end

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      mix_sum = mix_sum + {{LOG_NV{1'b0}}, v_out[i]};
    end
    mix_sample = mix_sum[SUM_W-1:LOG_NV];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      scnt         <= '0;
      dcnt         <= '0;
      sample_o     <= '0;
      sample_valid <= 1'b0;
      key_drop_o   <= 1'b0;
    end else begin
      key_drop_o   <= drop_evt;
      sample_valid <= sample_tick;
      if (sample_tick) sample_o <= mix_sample;
      if (en) begin
        scnt <= (scnt == SCNT_LAST) ? '0 : scnt + SCNT_W'(1);
        dcnt <= (dcnt == DCNT_LAST) ? '0 : dcnt + DCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_poly_voice_engine.sv
// Bench for poly_voice_engine: reference model feeding a sample scoreboard,
// a key-event vector table, and directed multi-cycle corner sequences.
module tb_poly_voice_engine;

  localparam int NV = 4;
  localparam int SD = 4;
  localparam int DD = 8;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        en = 1'b0;
  logic        key_valid = 1'b0;
  logic        key_on = 1'b0;
  logic [3:0]  key_code = '0;
  logic [15:0] key_step = '0;
  logic [1:0]  wave_sel = '0;
  logic [7:0]  sample_o;
  logic        sample_valid;
  logic [3:0]  voice_busy_o;
  logic        key_drop_o;

  always #5 clk = ~clk;

  poly_voice_engine #(
    .NUM_VOICES (NV),
    .PHASE_W    (16),
    .SAMPLE_W   (8),
    .AMP_W      (4),
    .KEY_W      (4),
    .SAMPLE_DIV (SD),
    .DECAY_DIV  (DD)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .en           (en),
    .key_valid    (key_valid),
    .key_on       (key_on),
    .key_code     (key_code),
    .key_step     (key_step),
    .wave_sel     (wave_sel),
    .sample_o     (sample_o),
    .sample_valid (sample_valid),
    .voice_busy_o (voice_busy_o),
    .key_drop_o   (key_drop_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: state 0 idle, 1 held, 2 release
  int          m_state [NV];
  logic [3:0]  m_code  [NV];
  logic [15:0] m_step  [NV];
  logic [15:0] m_phase [NV];
  int          m_amp   [NV];
  int          m_scnt, m_dcnt;
  bit          m_valid, m_drop;
  logic [7:0]  exp_q [$];

  function automatic int m_vout(int v);
    logic [15:0] p;
    logic [7:0]  w, t;
    p = m_phase[v];
    t = p[14:7];
    case (wave_sel)
      2'd0:    w = p[15] ? 8'hFF : 8'h00;
      2'd1:    w = p[15:8];
      2'd2:    w = p[15] ? ~t : t;
      default: w = 8'h00;
    endcase
    if (m_state[v] == 0) return 0;
    return (int'(w) * m_amp[v]) / 16;
  endfunction

  always @(posedge clk or negedge n_rst) begin : model
    int sum, ld, rt, rl;
    bit stick, dtick;
    if (!n_rst) begin
      for (int v = 0; v < NV; v++) begin
        m_state[v] = 0; m_code[v] = 0; m_step[v] = 0; m_phase[v] = 0; m_amp[v] = 0;
      end
      m_scnt = 0; m_dcnt = 0; m_valid = 0; m_drop = 0;
      exp_q.delete();
    end else begin
      stick = en && (m_scnt == SD - 1);
      dtick = en && (m_dcnt == DD - 1);
      sum = 0;
      for (int v = 0; v < NV; v++) sum += m_vout(v);
      m_valid = stick;
      if (stick) exp_q.push_back(8'(sum / 4));
      m_drop = 0; ld = -1; rt = -1; rl = -1;
      if (key_valid && key_on) begin
        for (int v = NV - 1; v >= 0; v--) if (m_state[v] != 0 && m_code[v] == key_code) rt = v;
        if (rt < 0) for (int v = NV - 1; v >= 0; v--) if (m_state[v] == 0) ld = v;
        if (rt < 0 && ld < 0) m_drop = 1;
      end else if (key_valid) begin
        for (int v = NV - 1; v >= 0; v--) if (m_state[v] == 1 && m_code[v] == key_code) rl = v;
      end
      for (int v = 0; v < NV; v++) begin
        if (v == ld) begin
          m_state[v] = 1; m_code[v] = key_code; m_step[v] = key_step; m_phase[v] = 0; m_amp[v] = 15;
        end else begin
          if (en && m_state[v] != 0) m_phase[v] = m_phase[v] + m_step[v];
          if (v == rt) begin
            m_state[v] = 1; m_amp[v] = 15; m_step[v] = key_step;
          end else if (v == rl) begin
            m_state[v] = 2;
          end else if (dtick && m_state[v] == 2) begin
            m_amp[v] = m_amp[v] - 1;
            if (m_amp[v] == 0) m_state[v] = 0;
          end
        end
      end
      if (en) begin
        m_scnt = (m_scnt + 1) % SD;
        m_dcnt = (m_dcnt + 1) % DD;
      end
    end
  end

  // Per-cycle monitor: status against the model, samples against the scoreboard.
  always @(negedge clk) begin : monitor
    logic [3:0] eb;
    logic [7:0] e;
    if (n_rst) begin
      for (int v = 0; v < NV; v++) eb[v] = (m_state[v] != 0);
      check("mon_busy", voice_busy_o, eb);
      check("mon_drop", key_drop_o, m_drop);
      check("mon_valid", sample_valid, m_valid);
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL mon_sample: got 0x%0h with no expected sample queued", sample_o);
        end else begin
          e = exp_q.pop_front();
          check("mon_sample", sample_o, e);
        end
      end
    end
  end

  typedef struct {
    bit          kv;
    bit          kon;
    logic [3:0]  code;
    logic [15:0] step;
    logic [3:0]  busy;
    bit          drop;
  } vec_t;

  vec_t tbl [11];

  task automatic drive_key(input bit kv, input bit kon, input logic [3:0] c, input logic [15:0] s);
    @(negedge clk);
    key_valid = kv; key_on = kon; key_code = c; key_step = s;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cyc, output bit ok);
    cyc = 0; ok = 0;
    while (!ok && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      if (sample_valid) ok = 1;
    end
  endtask

  task automatic hold_reset();
    @(negedge clk);
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin : stim
    int  cyc, n;
    bit  ok;

    tbl[0]  = '{1'b1, 1'b1, 4'd1, 16'h0100, 4'h1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'd2, 16'h0200, 4'h3, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 4'd3, 16'h0300, 4'h7, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 4'd4, 16'h0400, 4'hF, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 4'd5, 16'h0500, 4'hF, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 4'hF, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 4'd2, 16'h0000, 4'hF, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 4'd7, 16'h0700, 4'hF, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 4'd2, 16'h0250, 4'hF, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 4'd9, 16'h0000, 4'hF, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 4'd2, 16'h0000, 4'hF, 1'b0};

    // Reset state and first sample timing
    en = 1'b1; wave_sel = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sample_o", sample_o, 0);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_busy", voice_busy_o, 0);
    check("rst_drop", key_drop_o, 0);
    @(negedge clk);
    n_rst = 1'b1;
    wait_valid(20, cyc, ok);
    check("first_valid_seen", ok, 1);
    check("first_valid_clocks", cyc, 4);
    check("first_sample", sample_o, 0);

    // Single saw voice, load placed one edge before a tick so ticks see phase 0, 0x4000, 0x8000
    @(posedge clk);
    @(posedge clk);
    drive_key(1, 1, 4'd5, 16'h1000);
    check("saw_busy", voice_busy_o, 4'b0001);
    wait_valid(10, cyc, ok);
    check("saw_s0_seen", ok, 1);
    check("saw_s0", sample_o, 8'h00);
    wait_valid(10, cyc, ok);
    check("saw_s1_seen", ok, 1);
    check("saw_s1_phase4000", sample_o, 8'h0F);
    wait_valid(10, cyc, ok);
    check("saw_s2_seen", ok, 1);
    check("saw_s2_phase8000", sample_o, 8'h1E);

    // Allocation / overflow / release / retrigger vector table
    hold_reset();
    for (int i = 0; i < 11; i++) begin
      drive_key(tbl[i].kv, tbl[i].kon, tbl[i].code, tbl[i].step);
      check($sformatf("tbl%0d_busy", i), voice_busy_o, tbl[i].busy);
      check($sformatf("tbl%0d_drop", i), key_drop_o, tbl[i].drop);
    end

    // Full square: four voices loaded while frozen, then run in lockstep
    en = 1'b0; wave_sel = 2'd0;
    hold_reset();
    for (int c = 1; c <= 4; c++) drive_key(1, 1, 4'(c), 16'h8000);
    check("sq_busy", voice_busy_o, 4'hF);
    repeat (6) begin
      @(posedge clk);
      #1;
      check("en0_no_valid", sample_valid, 0);
    end
    @(negedge clk);
    en = 1'b1;
    wait_valid(10, cyc, ok);
    check("sq_valid_seen", ok, 1);
    check("sq_valid_clocks", cyc, 4);
    check("sq_sample", sample_o, 8'hEF);
    @(negedge clk);
    en = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      check("en0_hold_valid", sample_valid, 0);
      check("en0_hold_sample", sample_o, 8'hEF);
    end
    @(negedge clk);
    en = 1'b1;

    // Release and decay to idle, then voice 0 reused
    wave_sel = 2'd1;
    hold_reset();
    drive_key(1, 1, 4'd5, 16'h1000);
    repeat (5) @(posedge clk);
    drive_key(1, 0, 4'd5, 16'h0000);
    n = 0;
    while (voice_busy_o[0] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (!(n >= 113 && n <= 120)) begin
      n_bad++;
      $display("FAIL decay_clocks: got %0d clocks, expected 113..120", n);
    end
    drive_key(1, 1, 4'd9, 16'h0800);
    check("reuse_busy", voice_busy_o, 4'b0001);
    repeat (12) @(posedge clk);

    // Retrigger mid-release, then asynchronous reset mid-decay
    wave_sel = 2'd2;
    hold_reset();
    drive_key(1, 1, 4'd5, 16'h1000);
    drive_key(1, 0, 4'd5, 16'h0000);
    repeat (30) @(posedge clk);
    drive_key(1, 1, 4'd5, 16'h2000);
    check("retrig_busy", voice_busy_o, 4'b0001);
    check("retrig_drop", key_drop_o, 0);
    repeat (8) @(posedge clk);
    drive_key(1, 0, 4'd5, 16'h0000);
    repeat (20) @(posedge clk);
    #1;
    check("pre_reset_busy", voice_busy_o, 4'b0001);
    #1;
    n_rst = 1'b0;
    #1;
    check("async_rst_busy", voice_busy_o, 0);
    check("async_rst_valid", sample_valid, 0);
    check("async_rst_sample", sample_o, 0);
    check("async_rst_drop", key_drop_o, 0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/poly_voice_engine.md
# poly_voice_engine

Polyphonic successor to the single-voice oscillator/waveshaper path. It holds NUM_VOICES phase-accumulator voices, allocates them from key press/release events, and applies a per-voice release decay. It mixes all voices into one SAMPLE_W-bit sample on a fixed sample tick. It sits between the keypad encoder/frequency lookup, which supplies a step per key, and the pwm block.

## Interface
- NUM_VOICES, default 4: voice count; power of two, at least 2.
- PHASE_W, default 16: phase accumulator width; must be at least SAMPLE_W+1.
- SAMPLE_W, default 8: sample width.
- AMP_W, default 4: amplitude width; AMP_MAX = 2^AMP_W-1.
- KEY_W, default 4: key code width.
- SAMPLE_DIV, default 256: clocks per sample tick.
- DECAY_DIV, default 4096: clocks per decay tick.

Ports:
- clk  in  1  system clock; the block uses this single clock.
- n_rst  in  1  reset, asynchronous, active-low.
- en  in  1  run enable.
- key_valid  in  1  one-cycle key event strobe.
- key_on  in  1  1 = press, 0 = release.
- key_code  in  KEY_W  key identity.
- key_step  in  PHASE_W  phase increment per clock; used on press only.
- wave_sel  in  2  global waveform: 0 square, 1 saw, 2 triangle, 3 silent.
- sample_o  out  SAMPLE_W  mixed sample; feeds pwm.
- sample_valid  out  1  one-cycle pulse when sample_o updates.
- voice_busy_o  out  NUM_VOICES  voice i is not IDLE.
- key_drop_o  out  1  one-cycle pulse when a press is dropped because no voice is free.

## Operation
- Per-voice state: IDLE, HELD, RELEASE. Each voice also holds code, step, phase, and amp.
- Press event (key_valid=1, key_on=1):
  - If any non-IDLE voice has a matching code, retrigger it: state becomes HELD, amp becomes AMP_MAX, step becomes key_step, phase is unchanged.
  - Otherwise, the lowest-index IDLE voice loads code and step, sets phase=0, amp=AMP_MAX, state=HELD.
  - If no voice is IDLE, pulse key_drop_o. No voice changes.
- Release event (key_on=0): the HELD voice with a matching code goes to RELEASE. With no HELD match, nothing happens.
- Decay tick: a free-running counter pulses every DECAY_DIV clocks while en=1. On each pulse, every RELEASE voice does amp -= 1. When amp reaches 0, the voice goes to IDLE.
- Phase: while en=1, each non-IDLE voice does phase += step every clock, modulo 2^PHASE_W.
- Waveforms, with p = phase:
  - Square: all ones if p[MSB]=1, else 0.
  - Saw: p[PHASE_W-1 -: SAMPLE_W].
  - Triangle: t = p[PHASE_W-2 -: SAMPLE_W]. Output t when p[MSB]=0, else ~t.
  - Silent: 0.
- Voice output = (wave * amp) >> AMP_W. IDLE voices output 0.
- Mix: sum all voice outputs at width SAMPLE_W+log2(NUM_VOICES), then sample = sum >> log2(NUM_VOICES).
- en=0:
  - Phases, the sample counter and the decay counter freeze.
  - sample_o holds its value and sample_valid stays 0.
  - Key events are still processed.
- Event priority within a cycle: the key event is evaluated against the registered state. A voice that reaches amp 0 in that same cycle still counts as busy. If a key retriggers a voice during that voice's decay tick, the retrigger wins.

## Timing
- Reset value of every output is 0. All voices start IDLE with phase, amp, code and step at 0. Both tick counters reset to 0.
- Key event at edge k: voice_busy_o and key_drop_o reflect it after edge k. Latency is one cycle.
- Sample tick: the cycle in which the sample counter equals SAMPLE_DIV-1. sample_o and sample_valid are registered at that edge; sample_valid is high for exactly the following cycle.
- The decay counter and sample counter are independent. Both wrap to 0 after their terminal value.
- Reset asserted mid-operation clears everything asynchronously. The first sample after release from reset arrives SAMPLE_DIV clocks later.

## Structure
- synth_pkg holds:
  - voice_state_t (IDLE/HELD/RELEASE) and wave_t (SQUARE/SAW/TRI/SILENT) enums.
  - The wave-shaping function.
- Sub-module synth_voice, instantiated NUM_VOICES times via generate. It contains the state, phase accumulator, amp register, waveshaping and amplitude scaling.
- poly_voice_engine contains:
  - Match and priority-encode allocation logic.
  - The tick counters.
  - The adder tree / accumulation and the output registers.

## Test plan
Bench parameters: NUM_VOICES=4, PHASE_W=16, SAMPLE_W=8, AMP_W=4, SAMPLE_DIV=4, DECAY_DIV=8.
- Reset: hold n_rst low for 3 clocks, then release. All outputs are 0. The first sample_valid arrives 4 clocks after release, with sample_o=0.
- Single saw voice: press code 5 with step 0x1000 and wave_sel=1. voice_busy_o=4'b0001 one cycle later. At the tick where phase=0x4000: wave=0x40, scaled=0x3C, sample_o=0x0F.
- Overflow: press codes 1-5 on consecutive cycles. voice_busy_o=4'hF. The fifth press pulses key_drop_o for 1 cycle and no voice changes.
- Full square: 4 voices, wave_sel=0, all phase MSBs set. Each voice gives 0xEF, the sum is 956, sample_o=0xEF.
- Release/decay: release code 5. amp steps 15→0 over 15 decay ticks, and bit 0 of voice_busy_o clears after 15 decay ticks (≤128 clocks). A following press of code 9 reuses voice 0 with phase=0.
- Retrigger and reset: press code 5 again mid-release. Amp returns to 15, phase stays continuous, and no second voice is allocated. Asserting n_rst mid-decay zeroes all state in the same cycle.
